// File: rtl/regwb_queue.sv
// regwb_queue: in-order writeback commit queue feeding the register file write port.
// Source A (ALU) has strict priority over source B (mul/div/load); one enqueue and
// one dequeue per clock at most. Writes to r0 are handshaked then dropped.
// Optional feature macro: REGWB_FWD_EN adds fwd_hit_A/B and fwd_data_A/B outputs.
module regwb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [4:0]              a_addr,
  input  logic [31:0]             a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [4:0]              b_addr,
  input  logic [31:0]             b_data,
  output logic                    should_write,
  output logic [31:0]             write_address,
  output logic [31:0]             write_data,
  input  logic [4:0]              query_addr_A,
  input  logic [4:0]              query_addr_B,
  output logic                    hazard_A,
  output logic                    hazard_B,
  output logic [$clog2(DEPTH):0]  count
`ifdef REGWB_FWD_EN
  ,
  output logic                    fwd_hit_A,
  output logic                    fwd_hit_B,
  output logic [31:0]             fwd_data_A,
  output logic [31:0]             fwd_data_B
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    out_addr;
  logic          full;
  logic          enq;
  logic          deq;
  logic [4:0]    in_addr;
  logic [31:0]   in_data;
  logic [AW-1:0] slot;
  logic          qhit_a;
  logic          qhit_b;
  logic [31:0]   qdata_a;
  logic [31:0]   qdata_b;

  assign write_address = {27'b0, out_addr};

  // Handshake, source selection and enqueue/dequeue decisions from pre-edge state
  always_comb begin
    full    = (count == CW'(DEPTH));
    a_ready = rst_n & ~full;
    b_ready = rst_n & ~full & ~a_valid;
    in_addr = a_valid ? a_addr : b_addr;
    in_data = a_valid ? a_data : b_data;
    enq     = ((a_valid & a_ready) | (b_valid & b_ready)) & (in_addr != '0);
    deq     = (count != '0);
  end

  // Scan occupied slots oldest to youngest; later matches overwrite so the youngest wins
  always_comb begin
    slot    = '0;
    qhit_a  = 1'b0;
    qhit_b  = 1'b0;
    qdata_a = '0;
    qdata_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if (mem_addr[slot] == query_addr_A) begin
          qhit_a  = 1'b1;
          qdata_a = mem_data[slot];
        end
        if (mem_addr[slot] == query_addr_B) begin
          qhit_b  = 1'b1;
          qdata_b = mem_data[slot];
        end
      end
    end
    hazard_A = (query_addr_A != '0) &
               (qhit_a | (should_write & (out_addr == query_addr_A)));
    hazard_B = (query_addr_B != '0) &
               (qhit_b | (should_write & (out_addr == query_addr_B)));
  end

`ifdef REGWB_FWD_EN
  // Forwarded value: queued youngest match first, else the entry being written now
  always_comb begin
    fwd_hit_A  = hazard_A;
    fwd_hit_B  = hazard_B;
    fwd_data_A = '0;
    fwd_data_B = '0;
    if (hazard_A) fwd_data_A = qhit_a ? qdata_a : write_data;
    if (hazard_B) fwd_data_B = qhit_b ? qdata_b : write_data;
  end
`endif

  // Entry storage; no reset needed since occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      should_write <= 1'b0;
      out_addr     <= '0;
      write_data   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) begin
        should_write <= 1'b1;
        out_addr     <= mem_addr[rd_ptr];
        write_data   <= mem_data[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
      end else begin
        should_write <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_regwb_queue.sv
// tb_regwb_queue: directed plus random stimulus against a queue-based reference model.
module tb_regwb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        should_write;
  logic [31:0] write_address, write_data;
  logic [4:0]  query_addr_A, query_addr_B;
  logic        hazard_A, hazard_B;
  logic [$clog2(DEPTH):0] count;
`ifdef REGWB_FWD_EN
  logic        fwd_hit_A, fwd_hit_B;
  logic [31:0] fwd_data_A, fwd_data_B;
`endif

  regwb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .should_write(should_write), .write_address(write_address), .write_data(write_data),
    .query_addr_A(query_addr_A), .query_addr_B(query_addr_B),
    .hazard_A(hazard_A), .hazard_B(hazard_B), .count(count)
`ifdef REGWB_FWD_EN
    , .fwd_hit_A(fwd_hit_A), .fwd_hit_B(fwd_hit_B),
    .fwd_data_A(fwd_data_A), .fwd_data_B(fwd_data_B)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_sw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_haz(input logic [4:0] qa);
    if (qa == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].a == qa) return 1'b1;
    return m_sw && (m_wa == qa);
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] qa);
    if (qa == 5'd0) return 32'd0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].a == qa) return q[i].d;
    if (m_sw && m_wa == qa) return m_wd;
    return 32'd0;
  endfunction

  task automatic check_all(input logic av);
    logic f;
    f = (q.size() == DEPTH);
    chk("a_ready", 32'(a_ready), 32'(!f));
    chk("b_ready", 32'(b_ready), 32'(!f && !av));
    chk("count", 32'(count), 32'(q.size()));
    chk("should_write", 32'(should_write), 32'(m_sw));
    chk("write_address", write_address, {27'b0, m_wa});
    chk("write_data", write_data, m_wd);
    chk("hazard_A", 32'(hazard_A), 32'(m_haz(query_addr_A)));
    chk("hazard_B", 32'(hazard_B), 32'(m_haz(query_addr_B)));
`ifdef REGWB_FWD_EN
    chk("fwd_hit_A", 32'(fwd_hit_A), 32'(m_haz(query_addr_A)));
    chk("fwd_hit_B", 32'(fwd_hit_B), 32'(m_haz(query_addr_B)));
    chk("fwd_data_A", fwd_data_A, m_fwd(query_addr_A));
    chk("fwd_data_B", fwd_data_B, m_fwd(query_addr_B));
`endif
  endtask

  // Called just after a negedge: drive, check, cross one posedge, land on the next negedge
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] qa, input logic [4:0] qb);
    logic accA, accB, f;
    ent_t e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    query_addr_A = qa; query_addr_B = qb;
    #1;
    check_all(av);
    f    = (q.size() == DEPTH);
    accA = av && !f;
    accB = bv && !f && !av;
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      m_sw = 1'b1; m_wa = e.a; m_wd = e.d;
    end else begin
      m_sw = 1'b0;
    end
    if (accA && aa != 5'd0) q.push_back('{a: aa, d: ad});
    else if (accB && ba != 5'd0) q.push_back('{a: ba, d: bd});
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] qa);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    query_addr_A = '0; query_addr_B = '0;
    q.delete(); m_sw = 1'b0; m_wa = '0; m_wd = '0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_sw", 32'(should_write), 32'd0);
    chk("reset_a_ready", 32'(a_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single write r5, hazard visible while queued and while written
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5);
    idle(5'd5);
    idle(5'd5);
    chk("r5_sw_low", 32'(should_write), 32'd0);

    // A and B together: A wins, B follows next cycle
    step(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 5'd3, 5'd4);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hBBBB, 5'd3, 5'd4);
    chk("r3_written", write_address, 32'd3);
    idle(5'd4);
    chk("r4_written", write_address, 32'd4);
    idle(5'd0);

    // back-to-back A writes r1..r5
    for (int i = 1; i <= 5; i++)
      step(1'b1, 5'(i), 32'(i * 16'h111), 1'b0, 5'd0, 32'd0, 5'(i), 5'd2);
    idle(5'd5);
    idle(5'd5);

    // write to r0 is discarded
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd0);
    chk("r0_sw", 32'(should_write), 32'd0);

    // two writes to r7: forward the younger value
    step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    idle(5'd7);
    idle(5'd7);

    // asynchronous reset mid-drain
    step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    step(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
    a_valid = 1'b1; a_addr = 5'd11; a_data = 32'hB0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_sw", 32'(should_write), 32'd0);
    chk("rst_mid_wa", write_address, 32'd0);
    chk("rst_mid_wd", write_data, 32'd0);
    chk("rst_mid_a_ready", 32'(a_ready), 32'd0);
    chk("rst_mid_b_ready", 32'(b_ready), 32'd0);
    q.delete(); m_sw = 1'b0; m_wa = '0; m_wd = '0;
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(5'd10);

    // random traffic
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    repeat (3) idle(5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
